// File: rtl/dram_port_arbiter_if.sv
// Bundle of core-side request signals and the shared memory port.
//
// Handshake: a core raises req[i] with we/addr/wdata valid and keeps them
// stable until gnt[i] is seen high; the transaction completes on the rising
// edge where req[i] && gnt[i]. gnt acts as the per-core "ready" and is
// combinational. Reads answer later with a one-cycle rvalid[i] pulse
// (no back-pressure), and rdata is valid only while some rvalid bit is set.
interface dram_port_arbiter_if #(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        we;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        gnt;
  logic [N_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Cores plus memory side.
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among N_CORES cores.
// One transaction per cycle; read data is routed back MEM_LAT cycles later
// using a shift pipeline of one-hot core IDs.
module dram_port_arbiter #(
  parameter int  N_CORES = 2,
  parameter int  ADDR_W  = 12,
  parameter int  DATA_W  = 32,
  parameter int  MEM_LAT = 1,
  localparam int PTR_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dram_port_arbiter_if.slave   bus,
  output logic [PTR_W-1:0]     dbg_ptr_o
);

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand_idx;
  logic               found;
  int                 cand;
  logic [N_CORES-1:0] gnt_d;
  logic [N_CORES-1:0] rd_id;
  logic [N_CORES-1:0] pipe_q [MEM_LAT];

  // Scan from ptr_q upward (modulo N_CORES); first requester wins.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int j = 0; j < N_CORES; j++) begin
      cand = int'(ptr_q) + j;
      if (cand >= N_CORES) cand = cand - N_CORES;
      cand_idx = PTR_W'(cand);
      if (!found && bus.req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
    if (!rst) found = 1'b0;
  end

  // Drive the memory port from the winner and compute the next pointer.
  always_comb begin
    gnt_d         = '0;
    bus.mem_en    = found;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    ptr_d         = ptr_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      ptr_d      = (win == PTR_W'(N_CORES - 1)) ? '0 : win + PTR_W'(1);
    end
    for (int k = 0; k < N_CORES; k++) begin
      if (gnt_d[k]) begin
        bus.mem_we    = bus.we[k];
        bus.mem_addr  = bus.addr[k*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.wdata[k*DATA_W +: DATA_W];
      end
    end
    rd_id = bus.mem_we ? '0 : gnt_d;
  end

  // Pointer register and read-return ID pipeline; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int s = 0; s < MEM_LAT; s++) pipe_q[s] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pipe_q[0] <= rd_id;
      for (int s = 1; s < MEM_LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign bus.gnt    = gnt_d;
  assign bus.rvalid = pipe_q[MEM_LAT-1];
  assign bus.rdata  = bus.mem_rdata;
  assign dbg_ptr_o  = ptr_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: three instances (N=2/LAT=1, N=4/LAT=3,
// N=4/LAT=2) driven with directed vectors. Expected grants and read returns,
// tagged with the cycle they must appear in, go into per-instance queues;
// negedge monitors pop and compare whenever gnt or rvalid is non-zero.
module tb_dram_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a, rst_b, rst_c;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  dram_port_arbiter_if #(.N_CORES(2), .ADDR_W(12), .DATA_W(32)) if_a ();
  dram_port_arbiter_if #(.N_CORES(4), .ADDR_W(12), .DATA_W(32)) if_b ();
  dram_port_arbiter_if #(.N_CORES(4), .ADDR_W(12), .DATA_W(32)) if_c ();

  logic       ptr_a;
  logic [1:0] ptr_b;
  logic [1:0] ptr_c;

  dram_port_arbiter #(.N_CORES(2), .ADDR_W(12), .DATA_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst_a), .bus(if_a.slave), .dbg_ptr_o(ptr_a));
  dram_port_arbiter #(.N_CORES(4), .ADDR_W(12), .DATA_W(32), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst_b), .bus(if_b.slave), .dbg_ptr_o(ptr_b));
  dram_port_arbiter #(.N_CORES(4), .ADDR_W(12), .DATA_W(32), .MEM_LAT(2)) u_c (
    .clk(clk), .rst(rst_c), .bus(if_c.slave), .dbg_ptr_o(ptr_c));

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_val(input logic [11:0] a);
    if (a == 12'h0A5) return 32'hDEADBEEF;
    return {8'hC0, a, a};
  endfunction

  logic [3:0]  mv_a, mv_b, mv_c;
  logic [47:0] mad_a, mad_b, mad_c;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      mv_a <= '0; mad_a <= '0;
    end else begin
      mv_a  <= {mv_a[2:0], if_a.mem_en & ~if_a.mem_we};
      mad_a <= {mad_a[35:0], if_a.mem_addr};
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mv_b <= '0; mad_b <= '0;
    end else begin
      mv_b  <= {mv_b[2:0], if_b.mem_en & ~if_b.mem_we};
      mad_b <= {mad_b[35:0], if_b.mem_addr};
    end
  end

  always @(posedge clk or negedge rst_c) begin
    if (!rst_c) begin
      mv_c <= '0; mad_c <= '0;
    end else begin
      mv_c  <= {mv_c[2:0], if_c.mem_en & ~if_c.mem_we};
      mad_c <= {mad_c[35:0], if_c.mem_addr};
    end
  end

  assign if_a.mem_rdata = mv_a[0] ? mem_val(mad_a[11:0])  : 32'h0;
  assign if_b.mem_rdata = mv_b[2] ? mem_val(mad_b[35:24]) : 32'h0;
  assign if_c.mem_rdata = mv_c[1] ? mem_val(mad_c[23:12]) : 32'h0;

  // ---------------- scoreboard ----------------
  logic [95:0] exp_gq [3][$];
  logic [95:0] exp_rq [3][$];
  int total;
  int bad;

  function automatic logic [95:0] pk_g(input int c, input logic [7:0] g, input logic w,
                                       input logic [11:0] a, input logic [31:0] d);
    return {11'b0, 32'(c), g, w, a, d};
  endfunction

  function automatic logic [95:0] pk_r(input int c, input logic [7:0] rv, input logic [31:0] d);
    return {24'b0, 32'(c), rv, d};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic push_g(input int inst, input int c, input logic [7:0] g, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
    exp_gq[inst].push_back(pk_g(c, g, w, a, d));
  endtask

  task automatic push_r(input int inst, input int c, input logic [7:0] rv, input logic [31:0] d);
    exp_rq[inst].push_back(pk_r(c, rv, d));
  endtask

  // Pop-and-compare for one instance's observed outputs.
  task automatic mon(input int inst, input logic [7:0] g, input logic w, input logic [11:0] a,
                     input logic [31:0] d, input logic [7:0] rv, input logic [31:0] rd);
    logic [95:0] e;
    if (g != 8'h0) begin
      if (exp_gq[inst].size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant inst=%0d act_gnt=%b required=none cyc=%0d", inst, g, cyc);
      end else begin
        e = exp_gq[inst].pop_front();
        chk($sformatf("grant_inst%0d", inst), pk_g(cyc, g, w, a, d), e);
      end
    end
    if (rv != 8'h0) begin
      if (exp_rq[inst].size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid inst=%0d act_rvalid=%b required=none cyc=%0d", inst, rv, cyc);
      end else begin
        e = exp_rq[inst].pop_front();
        chk($sformatf("rvalid_inst%0d", inst), pk_r(cyc, rv, rd), e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 8'(if_a.gnt), if_a.mem_we, if_a.mem_addr, if_a.mem_wdata, 8'(if_a.rvalid), if_a.rdata);
    mon(1, 8'(if_b.gnt), if_b.mem_we, if_b.mem_addr, if_b.mem_wdata, 8'(if_b.rvalid), if_b.rdata);
    mon(2, 8'(if_c.gnt), if_c.mem_we, if_c.mem_addr, if_c.mem_wdata, 8'(if_c.rvalid), if_c.rdata);
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] rd4 [4];

  initial begin
    rd4 = '{32'hC0100100, 32'hC0101101, 32'hC0102102, 32'hC0103103};
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.req = '0; if_a.we = '0; if_a.addr = '0; if_a.wdata = '0;
    if_b.req = '0; if_b.we = '0; if_b.addr = '0; if_b.wdata = '0;
    if_c.req = '0; if_c.we = '0; if_c.addr = '0; if_c.wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset must not be granted.
    if_a.req = 2'b11; if_b.req = 4'b1111; if_c.req = 4'b1111;
    @(negedge clk);
    chk("rst_gnt_a", 96'(if_a.gnt), 96'(0));
    chk("rst_memen_a", 96'(if_a.mem_en), 96'(0));
    chk("rst_gnt_b", 96'(if_b.gnt), 96'(0));
    chk("rst_rvalid_b", 96'(if_b.rvalid), 96'(0));
    @(posedge clk);
    #1;
    if_a.req = '0; if_b.req = '0; if_c.req = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Test 1: idle after reset.
    @(negedge clk);
    chk("idle_gnt", 96'(if_a.gnt), 96'(0));
    chk("idle_memen", 96'(if_a.mem_en), 96'(0));
    chk("idle_rvalid", 96'(if_a.rvalid), 96'(0));
    chk("idle_ptr", 96'(ptr_a), 96'(0));
    @(posedge clk);
    #1;

    // Test 2: core1 read of 0x0A5, data back next cycle.
    if_a.we = 2'b00; if_a.addr = {12'h0A5, 12'h000}; if_a.wdata = '0; if_a.req = 2'b10;
    push_g(0, cyc, 8'b10, 1'b0, 12'h0A5, 32'h0);
    push_r(0, cyc + 1, 8'b10, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    if_a.req = '0;
    @(negedge clk);
    chk("t2_ptr_wrap", 96'(ptr_a), 96'(0));
    @(posedge clk);
    #1;

    // Test 3: both cores write continuously, strict alternation.
    if_a.we = 2'b11; if_a.addr = {12'h020, 12'h010};
    if_a.wdata = {32'h22222222, 32'h11111111}; if_a.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_g(0, cyc, 8'b01, 1'b1, 12'h010, 32'h11111111);
      else            push_g(0, cyc, 8'b10, 1'b1, 12'h020, 32'h22222222);
      @(negedge clk);
      chk($sformatf("t3_ptr_%0d", i), 96'(ptr_a), 96'(i % 2));
      @(posedge clk);
      #1;
    end
    if_a.req = '0;

    // Test 4: four reads on consecutive cycles, LAT=3.
    if_b.we = 4'b0000; if_b.wdata = '0;
    if_b.addr = {12'h103, 12'h102, 12'h101, 12'h100};
    for (int i = 0; i < 4; i++) begin
      if_b.req = 4'(1 << i);
      push_g(1, cyc, 8'(1 << i), 1'b0, 12'h100 + 12'(i), 32'h0);
      push_r(1, cyc + 3, 8'(1 << i), rd4[i]);
      @(posedge clk);
      #1;
    end
    if_b.req = '0;
    repeat (4) @(posedge clk);
    #1;

    // Test 5: pointer wrap from 3 with req=1001.
    chk("t5_ptr_start", 96'(ptr_b), 96'(0));
    if_b.we = 4'b1111;
    if_b.wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    if_b.req = 4'b0100;
    push_g(1, cyc, 8'b0100, 1'b1, 12'h102, 32'h33333333);
    @(posedge clk);
    #1;
    chk("t5_ptr_3", 96'(ptr_b), 96'(3));
    if_b.req = 4'b1001;
    push_g(1, cyc, 8'b1000, 1'b1, 12'h103, 32'h44444444);
    @(posedge clk);
    #1;
    chk("t5_ptr_wrap", 96'(ptr_b), 96'(0));
    if_b.req = 4'b0001;
    push_g(1, cyc, 8'b0001, 1'b1, 12'h100, 32'h11111111);
    @(posedge clk);
    #1;
    if_b.req = '0;
    chk("t5_ptr_after", 96'(ptr_b), 96'(1));

    // Test 6: core2 read, then reset one cycle later discards it.
    if_c.we = 4'b0000; if_c.wdata = '0;
    if_c.addr = {12'h0C3, 12'h0C2, 12'h0C1, 12'h0C0};
    if_c.req = 4'b0100;
    push_g(2, cyc, 8'b0100, 1'b0, 12'h0C2, 32'h0);
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    if_c.req = 4'b1010;
    @(negedge clk);
    chk("t6_rst_gnt", 96'(if_c.gnt), 96'(0));
    chk("t6_rst_memen", 96'(if_c.mem_en), 96'(0));
    chk("t6_rst_rvalid", 96'(if_c.rvalid), 96'(0));
    @(posedge clk);
    #1;
    rst_c = 1'b1;
    chk("t6_ptr_rst", 96'(ptr_c), 96'(0));
    push_g(2, cyc, 8'b0010, 1'b0, 12'h0C1, 32'h0);
    push_r(2, cyc + 2, 8'b0010, 32'hC00C10C1);
    @(posedge clk);
    #1;
    if_c.req = '0;
    repeat (6) @(posedge clk);
    #1;

    // Everything expected must have been observed.
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("gq_empty_%0d", k), 96'(exp_gq[k].size()), 96'(0));
      chk($sformatf("rq_empty_%0d", k), 96'(exp_rq[k].size()), 96'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
